// File: rtl/risc_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : risc_core_mc
// Description : Parametrised multi-cycle RISC core. Instruction and data
//               memories are reached through req/ack handshakes, so
//               wait-stated memories and I/O can be attached.
//               Instruction: opcode[4] | rd[REG_AW] | rs1[REG_AW] | imm[ADDR_W]
//               rs2 is taken from imm[REG_AW-1:0]. R0 is hardwired to zero.
// Ports       : clk, reset (async, active-high), run (execution enable)
//               imem_req/imem_addr/imem_rdata/imem_ack   - instruction fetch
//               dmem_req/dmem_we/dmem_addr/dmem_wdata/
//               dmem_rdata/dmem_ack                      - data access
//               pc_out (current PC), retired (1-cycle pulse per completed
//               instruction), halted (core parked after HALT)
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module risc_core_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_AW = 2,
    localparam int IW    = 4 + 2*REG_AW + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IW-1:0]     imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retired,
    output logic              halted
);

    localparam int         c_NREGS    = 2**REG_AW;
    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_LOAD  = 4'd2;
    localparam logic [3:0] c_OP_STORE = 4'd3;
    localparam logic [3:0] c_OP_JUMP  = 4'd4;
    localparam logic [3:0] c_OP_BEQZ  = 4'd5;
    localparam logic [3:0] c_OP_ADDI  = 4'd6;
    localparam logic [3:0] c_OP_HALT  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [IW-1:0]     r_ir;
    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic              r_imem_req;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_retired;
    logic              r_halted;

    // Instruction field decode
    logic [3:0]        w_op;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [ADDR_W-1:0] w_imm;
    logic [DATA_W-1:0] w_imm_d;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic [ADDR_W-1:0] w_daddr;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_op      = r_ir[IW-1 -: 4];
    assign w_rd      = r_ir[IW-5 -: REG_AW];
    assign w_rs1     = r_ir[IW-5-REG_AW -: REG_AW];
    assign w_imm     = r_ir[ADDR_W-1:0];
    assign w_rs2     = w_imm[REG_AW-1:0];
    // Immediate is zero-extended or truncated to the datapath width
    assign w_imm_d   = DATA_W'(w_imm);
    // R0 is never written, so it reads back as its reset value of zero
    assign w_rd_val  = r_regs[w_rd];
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];
    assign w_daddr   = ADDR_W'(w_rs1_val) + w_imm;
    assign w_pc_inc  = r_pc + ADDR_W'(1);

    // Single-cycle instruction results (everything except LOAD/STORE/HALT)
    logic              w_wb_en;
    logic [DATA_W-1:0] w_wb_val;
    logic [ADDR_W-1:0] w_next_pc;

    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_val  = w_rs1_val + w_rs2_val;
        w_next_pc = w_pc_inc;
        case (w_op)
            c_OP_ADD: begin
                w_wb_en  = 1'b1;
                w_wb_val = w_rs1_val + w_rs2_val;
            end
            c_OP_SUB: begin
                w_wb_en  = 1'b1;
                w_wb_val = w_rs1_val - w_rs2_val;
            end
            c_OP_ADDI: begin
                w_wb_en  = 1'b1;
                w_wb_val = w_rs1_val + w_imm_d;
            end
            c_OP_JUMP: w_next_pc = w_imm;
            c_OP_BEQZ: if (w_rd_val == '0) w_next_pc = w_imm;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_retired    <= 1'b0;
            r_halted     <= 1'b0;
            for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_retired <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == c_OP_LOAD || w_op == c_OP_STORE) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= (w_op == c_OP_STORE);
                        r_dmem_addr  <= w_daddr;
                        r_dmem_wdata <= w_rd_val;
                        r_state      <= S_MEM;
                    end else if (w_op == c_OP_HALT) begin
                        r_halted  <= 1'b1;
                        r_retired <= 1'b1;
                        r_state   <= S_HALTED;
                    end else begin
                        if (w_wb_en && w_rd != '0) r_regs[w_rd] <= w_wb_val;
                        r_pc       <= w_next_pc;
                        r_retired  <= 1'b1;
                        // run is sampled at retire: continue or park in IDLE
                        r_state    <= run ? S_FETCH : S_IDLE;
                        r_imem_req <= run;
                    end
                end
                S_MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        if (!r_dmem_we && w_rd != '0) r_regs[w_rd] <= dmem_rdata;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_retired  <= 1'b1;
                        r_state    <= run ? S_FETCH : S_IDLE;
                        r_imem_req <= run;
                    end
                end
                S_HALTED: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc_out     = r_pc;
    assign retired    = r_retired;
    assign halted     = r_halted;

endmodule
`default_nettype wire
